ma_arbiter: RTL
===============

Name: ma_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Montgomery multiplier (MA) among NREQ requesters, e.g. the T/U update paths of the exponentiation engine and a precompute unit.
- Latches the winning requester's operands, issues a one-cycle start pulse to MA, waits for MA finish, and returns the product with a done pulse.
- A watchdog aborts an operation if MA never finishes.
- Sits between the exponentiation controllers and a single MA instance.

Parameters:
- W, 256, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1023, maximum WAIT cycles before abort (must be ≥ MA worst-case latency)
- TW, 10, watchdog counter width (2^TW > TIMEOUT)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- mod_n  in  W  shared modulus, passed straight to MA
- grant  out  NREQ  one-hot, owner of the multiplier
- done  out  NREQ  one-cycle completion pulse to the owner
- err  out  NREQ  one-cycle timeout pulse to the owner
- result  out  W  last product, valid while done is high, held until the next DONE
- busy  out  1  high in any state except IDLE
- ma_a  out  W  latched operand A to MA
- ma_b  out  W  latched operand B to MA
- ma_n  out  W  equals mod_n
- ma_start  out  1  one-cycle start pulse to MA
- ma_result  in  W  MA product
- ma_finish  in  1  MA completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant, done, err, ma_start, busy = 0.
  - result, ma_a, ma_b = 0.
  - Round-robin pointer ptr=0; watchdog=0.
  - Reset mid-operation abandons the operation silently: no done or err. MA must be reset by the same rst_n.
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- IDLE:
  - If any req bit is high, choose the first set index scanning ptr, ptr+1, ... modulo NREQ.
  - Latch its req_a/req_b into ma_a/ma_b and register the index.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - ma_start=1 for exactly this one cycle; grant[idx]=1; watchdog cleared.
  - Go to WAIT.
  - ma_finish seen in this cycle is ignored.
- WAIT:
  - On ma_finish=1, latch ma_result into result and go to DONE.
  - Otherwise increment the watchdog. When it equals TIMEOUT, go to ABORT.
  - If ma_finish and timeout occur in the same cycle, finish wins.
- DONE:
  - done[idx]=1 for one cycle; set ptr=(idx+1) mod NREQ.
  - Go to IDLE.
- ABORT:
  - err[idx]=1 for one cycle; result unchanged; ptr=(idx+1) mod NREQ.
  - Go to IDLE.
- grant[idx] is high from ISSUE through DONE or ABORT inclusive. It is 0 in IDLE.
- Latency: with req sampled high in IDLE at edge k and ma_finish high in the first WAIT cycle:
  - ma_start is high in cycle k+1.
  - done is high in cycle k+3.
  - The next grant can start ISSUE at k+5.
- Requester rules:
  - Hold req and its operands until done or err. Operands are sampled only in IDLE, so later changes have no effect.
  - A req dropped mid-operation does not cancel it; done/err still pulse.
  - req still high in the cycle after done is treated as a new request.
- Fairness: a continuously requesting port is served within NREQ operations.
- Pointer wrap: after index NREQ-1 is served, ptr=0.
- Simultaneous requests in IDLE: exactly one grant per arbitration.

Test Plan:
- Single request, req[2]=1, a=3, b=5, MA model returns 15 after 4 cycles -> one ma_start pulse, grant=4'b0100, done=4'b0100 for one cycle, result=15, busy back to 0 the cycle after DONE.
- All four requesters held high, finish always after 2 cycles -> grant order 0,1,2,3,0; each done bit pulses once per round; never two grant bits set.
- MA model never finishes, TIMEOUT=20 -> err[idx] pulses exactly 20 WAIT cycles after ISSUE; no done; result keeps its prior value; next requester is served afterwards.
- ma_finish in the ISSUE cycle and again in the last watchdog cycle -> the first is ignored; the second completes with done, not err.
- rst_n pulled low during WAIT -> all outputs 0 asynchronously; no done/err after release; the next request is arbitrated from ptr=0.
- req[1] dropped after ISSUE while req[3] is pending -> done[1] still pulses; req[3] is granted next.

Source files
------------

// File: rtl/ma_arbiter.sv
// ma_arbiter: round-robin arbiter/sequencer sharing one Montgomery multiplier among NREQ requesters
//   in : clk, rst_n (async active-low), req[NREQ], req_a/req_b[NREQ*W] (packed i*W +: W),
//        mod_n[W], ma_result[W], ma_finish
//   out: grant/done/err[NREQ] (one-hot to owner), result[W], busy,
//        ma_a/ma_b/ma_n[W], ma_start
module ma_arbiter #(
  parameter int W       = 256,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [W-1:0]     mod_n,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  err,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic [W-1:0]     ma_a,
  output logic [W-1:0]     ma_b,
  output logic [W-1:0]     ma_n,
  output logic             ma_start,
  input  logic [W-1:0]     ma_result,
  input  logic             ma_finish
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ABORT} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx, r_ptr, w_pick;
  logic [TW-1:0] r_wd;
  logic [W-1:0] r_ma_a, r_ma_b, r_result;
  logic [NREQ-1:0] w_oh;
  // lowest rotation offset from r_ptr wins, so scan offsets downward
  always_comb begin
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) w_pick = IW'((int'(r_ptr) + k) % NREQ);
    end
  end
  // watchdog counts WAIT cycles 0..TIMEOUT-1; finish takes priority over timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = |req ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = ma_finish ? S_DONE : (r_wd == TW'(TIMEOUT - 1)) ? S_ABORT : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_wd     <= '0;
      r_ma_a   <= '0;
      r_ma_b   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (|req) begin
          r_idx  <= w_pick;
          r_ma_a <= req_a[w_pick*W +: W];
          r_ma_b <= req_b[w_pick*W +: W];
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (ma_finish) r_result <= ma_result;
        end
        S_DONE, S_ABORT: r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end
  assign w_oh     = NREQ'(1) << r_idx;
  assign grant    = (r_state != S_IDLE) ? w_oh : '0;
  assign done     = (r_state == S_DONE) ? w_oh : '0;
  assign err      = (r_state == S_ABORT) ? w_oh : '0;
  assign busy     = r_state != S_IDLE;
  assign ma_start = r_state == S_ISSUE;
  assign ma_a     = r_ma_a;
  assign ma_b     = r_ma_b;
  assign ma_n     = mod_n;
  assign result   = r_result;
endmodule
